// File: rtl/dense_mac_layer.sv
// Fully-connected layer: y[o] = sat(bias[o] + sum_i w[o][i]*x[i]) in signed fixed point,
// one shared MAC, weights streamed from a synchronous memory with one-cycle read latency.
module dense_mac_layer #(
   parameter int IN_COUNT   = 64,
   parameter int OUT_COUNT  = 128,
   parameter int DATA_WIDTH = 16,
   parameter int Q_FRAC     = 8,
   parameter int ACC_WIDTH  = 40,
   localparam int N          = IN_COUNT * OUT_COUNT,
   localparam int ADDR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [DATA_WIDTH*IN_COUNT-1:0]   data_in,
   input  logic [DATA_WIDTH*OUT_COUNT-1:0]  bias_in,
   output logic                             w_rd_en,
   output logic [ADDR_WIDTH-1:0]            w_addr,
   input  logic [DATA_WIDTH-1:0]            w_data,
   output logic [DATA_WIDTH*OUT_COUNT-1:0]  data_out,
   output logic                             busy,
   output logic                             done
);

   localparam int ELEM_WIDTH = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
   localparam int ROW_WIDTH  = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
   localparam int PROD_WIDTH = 2 * DATA_WIDTH;

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   if (ACC_WIDTH < PROD_WIDTH + $clog2(IN_COUNT) + 1) begin : g_acc_width_check
      $error("dense_mac_layer: ACC_WIDTH too small for worst-case dot product");
   end

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t                        state;
   logic                          rd_pending;
   logic [ELEM_WIDTH-1:0]         elem;
   logic [ROW_WIDTH-1:0]          row;
   logic signed [ACC_WIDTH-1:0]   acc;

   logic [DATA_WIDTH-1:0]         x_sel;
   logic signed [PROD_WIDTH-1:0]  prod;
   logic signed [ACC_WIDTH-1:0]   sum;
   logic signed [ACC_WIDTH-1:0]   shifted;
   logic [DATA_WIDTH-1:0]         sat_val;
   logic                          last_elem;
   logic                          last_row;
   logic [ROW_WIDTH-1:0]          next_row;
   logic [DATA_WIDTH-1:0]         next_bias;

   function automatic logic signed [ACC_WIDTH-1:0] bias_to_acc(input logic [DATA_WIDTH-1:0] b);
      return {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b} << Q_FRAC;
   endfunction

   // NOTE: combinational logic uses blocking '=' with every output assigned first, so no latch is inferred.
   always_comb begin
      x_sel     = data_in[int'(elem)*DATA_WIDTH +: DATA_WIDTH];
      prod      = $signed(w_data) * $signed(x_sel);
      sum       = acc + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
      shifted   = sum >>> Q_FRAC;
      sat_val   = shifted[DATA_WIDTH-1:0];
      if (shifted > SAT_MAX) begin
         sat_val = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         sat_val = SAT_MIN[DATA_WIDTH-1:0];
      end
      last_elem = (elem == ELEM_WIDTH'(IN_COUNT - 1));
      last_row  = (row == ROW_WIDTH'(OUT_COUNT - 1));
      next_row  = last_row ? '0 : row + 1'b1;
      next_bias = bias_in[int'(next_row)*DATA_WIDTH +: DATA_WIDTH];
   end

   // NOTE: data_out is an output register bank, so it is cleared by the async reset along with the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         w_rd_en    <= 1'b0;
         w_addr     <= '0;
         data_out   <= '0;
         acc        <= '0;
         rd_pending <= 1'b0;
         elem       <= '0;
         row        <= '0;
      end else begin
         done       <= 1'b0;
         // Memory returns data one cycle after the request, so validity trails w_rd_en by one edge.
         rd_pending <= w_rd_en;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  acc     <= bias_to_acc(bias_in[DATA_WIDTH-1:0]);
                  w_rd_en <= 1'b1;
                  w_addr  <= '0;
                  elem    <= '0;
                  row     <= '0;
               end
            end
            RUN: begin
               if (w_rd_en) begin
                  if (w_addr == ADDR_WIDTH'(N - 1)) begin
                     w_rd_en <= 1'b0;
                     w_addr  <= '0;
                  end else begin
                     w_addr <= w_addr + 1'b1;
                  end
               end
               if (rd_pending) begin
                  if (last_elem) begin
                     data_out[int'(row)*DATA_WIDTH +: DATA_WIDTH] <= sat_val;
                     acc  <= bias_to_acc(next_bias);
                     elem <= '0;
                     row  <= next_row;
                     if (last_row) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     acc  <= sum;
                     elem <= elem + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dense_mac_layer.md
# dense_mac_layer

Fully-connected layer stage directly upstream of the vector sigmoid block. Computes `y[o] = sat(bias[o] + Σ_i w[o][i]·x[i])` in signed Q(DATA_WIDTH−Q_FRAC).Q_FRAC using one shared multiply-accumulate. Weights stream from an external synchronous memory. The flattened `data_out` bus and the `done` pulse wire directly to the sigmoid stage's `data_in` and `start`.

## Interface
- IN_COUNT, 64, input vector length (≥1)
- OUT_COUNT, 128, output vector length (≥1)
- DATA_WIDTH, 16, signed element width
- Q_FRAC, 8, fractional bits of x, w, bias, y
- ACC_WIDTH, 40, accumulator width; must be ≥ 2·DATA_WIDTH + clog2(IN_COUNT) + 1, else `$error` in simulation
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a layer pass; sampled only when idle
- data_in  in  DATA_WIDTH·IN_COUNT  x vector, element i at `[i·DATA_WIDTH +: DATA_WIDTH]`; held stable while busy
- bias_in  in  DATA_WIDTH·OUT_COUNT  bias vector, same packing; held stable while busy
- w_rd_en  out  1  weight read request
- w_addr  out  clog2(IN_COUNT·OUT_COUNT) (min 1)  row-major weight address o·IN_COUNT+i
- w_data  in  DATA_WIDTH  weight; valid the cycle after the matching w_rd_en/w_addr cycle
- data_out  out  DATA_WIDTH·OUT_COUNT  y vector, packed as data_in
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse; data_out complete

## Operation
- Reset: all outputs 0 (data_out, busy, done, w_rd_en, w_addr). Internal state returns to IDLE. Acts immediately, including mid-pass. An aborted pass is discarded.
- States: IDLE → RUN → IDLE. No other states.
- IDLE: on an edge with start=1, enter RUN. Set busy=1. Load accumulator with sign-extended bias[0]<<Q_FRAC. Register w_rd_en=1, w_addr=0.
- RUN issue side: w_addr increments by 1 each cycle through N−1, where N = IN_COUNT·OUT_COUNT. On the edge after address N−1 is presented, w_rd_en drops to 0 and w_addr returns to 0.
- RUN accumulate side: each edge with valid w_data adds the full-width product w_data·x[i] to the accumulator, for i = element index of the returning address. The product is 2·DATA_WIDTH signed, sign-extended to ACC_WIDTH.
- Row end (product for i = IN_COUNT−1 of row o):
  - Compute s = (acc + product) >>> Q_FRAC. This is an arithmetic shift, i.e. truncation toward −∞.
  - Saturate s to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] and write it to data_out slot o.
  - Reload the accumulator with bias[o+1]<<Q_FRAC. There is no bubble between rows.
- Last row end: done=1 for one cycle, busy=0, state → IDLE.
- data_out slots hold their values until overwritten by a later pass or by reset. Slots not yet rewritten in the current pass keep their prior values.
- start while busy is ignored. A start on the edge where busy falls is also ignored, because the state is still RUN at that edge. start is accepted on the next edge.
- IN_COUNT=1: every product is a row end. OUT_COUNT=1: a single row.

## Timing
- Let E0 be the edge sampling start.
- w_rd_en is high for exactly N cycles, from E0 to E_N. Address n is presented between E_n and E_{n+1}.
- w_data for address n arrives between E_{n+1} and E_{n+2}. It is accumulated at E_{n+2}.
- Slot o is written at E_{(o+1)·IN_COUNT+1}.
- done and busy-fall occur at E_{N+1}. The start-to-done latency is N+1 cycles. Back-to-back passes have a period of N+2 cycles.
- w_data is ignored when no read is outstanding.

## Test plan
- Identity (IN=2, OUT=2): w=[0x0100,0,0,0x0100], x=[0x0200,0xFF00], bias=0 → data_out=[0x0200,0xFF00]; done one cycle at E5; w_addr 0,1,2,3 on consecutive cycles.
- Bias only: all w=0, bias=[0x0080,0xFF80] → data_out=[0x0080,0xFF80].
- Saturation: x=w=0x7FFF in all slots → 0x7FFF. With w=0x8000 → 0x8000.
- Truncation: x=0x0001, w=0x0080 → 0x0000. x=0xFFFF, w=0x0080 → 0xFFFF (−1 LSB).
- Protocol: start pulsed at E2 and at the done edge → ignored, single done. Next start → a second full pass of identical latency. data_out of unwritten slots unchanged mid-pass.
- Reset mid-pass: rst_n low after E3 → busy, done, w_rd_en, w_addr, data_out all 0 immediately (asynchronously). After release, start → full pass with correct results and done at E_{N+1}.
